// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART transmit scheduler: FSM state codes, the
// frame header tag and the grant-id width helper.
package uart_sched_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HDR     = 3'd1;
   localparam logic [2:0] S_SEND    = 3'd2;
   localparam logic [2:0] S_WAIT_LO = 3'd3;
   localparam logic [2:0] S_WAIT_HI = 3'd4;

   localparam logic [7:0] C_HDR_TAG = 8'hA0;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, wrapping,
// with excluded requesters skipped only while another request is pending.
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int P_NUM_REQ = 4,
   parameter int W_ID      = id_width(P_NUM_REQ)
) (
   input  logic [P_NUM_REQ-1:0] req,
   input  logic [W_ID-1:0]      ptr,
   input  logic [P_NUM_REQ-1:0] excl_mask,
   output logic [P_NUM_REQ-1:0] onehot,
   output logic [W_ID-1:0]      id
);

   logic [P_NUM_REQ-1:0] cand;
   logic                 found;
   int                   idx;

   always_comb begin
      cand   = req & ~excl_mask;
      if (cand == '0) begin
         cand = req;
      end
      onehot = '0;
      id     = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < P_NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % P_NUM_REQ;
         if (!found && cand[idx]) begin
            found       = 1'b1;
            onehot[idx] = 1'b1;
            id          = W_ID'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART driver between P_NUM_REQ byte requesters with bounded-burst
// round-robin. Define UART_TX_SCHED_GRANT_ID_EN to prefix each new grant with 8'hA0|id.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int P_NUM_REQ    = 4,
   parameter int P_DATA_WIDTH = 8,
   parameter int P_MAX_BURST  = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [P_NUM_REQ-1:0]              i_req_valid,
   input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
   output logic [P_NUM_REQ-1:0]              o_req_ready,
   output logic [P_DATA_WIDTH-1:0]           o_user_tx_data,
   output logic                              o_user_tx_valid,
   input  logic                              i_user_tx_ready,
   output logic [id_width(P_NUM_REQ)-1:0]    o_grant_id,
   output logic                              o_busy
);

   localparam int W_ID = id_width(P_NUM_REQ);

   logic [2:0]              state;
   logic [W_ID-1:0]         ptr;
   logic [7:0]              burst_cnt;
   logic [P_DATA_WIDTH-1:0] tx_q;
`ifdef UART_TX_SCHED_GRANT_ID_EN
   logic [P_DATA_WIDTH-1:0] data_q;
   logic                    hdr_phase;
   logic [P_DATA_WIDTH-1:0] hdr_byte;
`endif

   logic [P_NUM_REQ-1:0]    excl_mask;
   logic [P_NUM_REQ-1:0]    arb_onehot;
   logic [W_ID-1:0]         arb_id;
   logic                    keep;
   logic                    burst_done;
   logic [P_NUM_REQ-1:0]    win_onehot;
   logic [W_ID-1:0]         win_id;
   logic                    any_req;
   logic                    grant_change;
   logic [P_DATA_WIDTH-1:0] req_byte;

   rr_arbiter #(
      .P_NUM_REQ (P_NUM_REQ),
      .W_ID      (W_ID)
   ) u_arb (
      .req       (i_req_valid),
      .ptr       (ptr),
      .excl_mask (excl_mask),
      .onehot    (arb_onehot),
      .id        (arb_id)
   );

   // A zero burst count means nothing has been granted since reset, so the
   // first grant is always treated as a grant change.
   always_comb begin
      burst_done = (burst_cnt >= 8'(P_MAX_BURST));
      keep       = (burst_cnt != 8'd0) && !burst_done && i_req_valid[o_grant_id];
      excl_mask  = '0;
      if (burst_done) begin
         excl_mask[o_grant_id] = 1'b1;
      end
      win_onehot = arb_onehot;
      win_id     = arb_id;
      if (keep) begin
         win_onehot             = '0;
         win_onehot[o_grant_id] = 1'b1;
         win_id                 = o_grant_id;
      end
      any_req      = |i_req_valid;
      grant_change = (burst_cnt == 8'd0) || (win_id != o_grant_id);
      req_byte     = i_req_data[int'(win_id)*P_DATA_WIDTH +: P_DATA_WIDTH];
`ifdef UART_TX_SCHED_GRANT_ID_EN
      hdr_byte     = P_DATA_WIDTH'(C_HDR_TAG) | P_DATA_WIDTH'(win_id);
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         ptr        <= '0;
         o_grant_id <= '0;
         burst_cnt  <= '0;
         tx_q       <= '0;
`ifdef UART_TX_SCHED_GRANT_ID_EN
         data_q     <= '0;
         hdr_phase  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  o_grant_id <= win_id;
                  if (grant_change) begin
                     burst_cnt <= 8'd1;
                     ptr       <= (win_id == W_ID'(P_NUM_REQ-1)) ? '0 : win_id + 1'b1;
                  end else if (burst_done) begin
                     burst_cnt <= 8'd1;
                  end else begin
                     burst_cnt <= burst_cnt + 8'd1;
                  end
`ifdef UART_TX_SCHED_GRANT_ID_EN
                  data_q <= req_byte;
                  if (grant_change) begin
                     tx_q      <= hdr_byte;
                     hdr_phase <= 1'b1;
                     state     <= S_HDR;
                  end else begin
                     tx_q  <= req_byte;
                     state <= S_SEND;
                  end
`else
                  tx_q  <= req_byte;
                  state <= S_SEND;
`endif
               end
            end
            S_HDR, S_SEND: begin
               if (i_user_tx_ready) begin
                  state <= S_WAIT_LO;
               end
            end
            S_WAIT_LO: begin
               if (!i_user_tx_ready) begin
                  state <= S_WAIT_HI;
               end
            end
            S_WAIT_HI: begin
               if (i_user_tx_ready) begin
`ifdef UART_TX_SCHED_GRANT_ID_EN
                  if (hdr_phase) begin
                     hdr_phase <= 1'b0;
                     tx_q      <= data_q;
                     state     <= S_SEND;
                  end else begin
                     state <= S_IDLE;
                  end
`else
                  state <= S_IDLE;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The accept pulse is combinational from IDLE, so it is masked while reset
   // is held to keep requesters from dropping bytes that were never latched.
   always_comb begin
      o_req_ready     = (state == S_IDLE && reset) ? win_onehot : '0;
      o_user_tx_valid = (state == S_SEND) || (state == S_HDR);
      o_user_tx_data  = tx_q;
      o_busy          = (state != S_IDLE);
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed scoreboard bench for uart_tx_scheduler with a byte-producer model
// per requester and a UART driver model that holds ready low for FRAME_LEN cycles.
module tb_uart_tx_scheduler;

   localparam int FRAME_LEN = 10;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  i_req_valid = '0;
   logic [31:0] i_req_data = '0;
   logic [3:0]  o_req_ready;
   logic [7:0]  o_user_tx_data;
   logic        o_user_tx_valid;
   logic        i_user_tx_ready = 1'b1;
   logic [1:0]  o_grant_id;
   logic        o_busy;

   int          tests_run = 0;
   int          tests_failed = 0;
   exp_t        exp_q[$];
   logic [7:0]  src_q[4][$];
   logic [3:0]  ready_seen = '0;
   bit          xfer_pending = 0;
   bit          drv_hold = 0;
   int          busy_cnt = 0;
   int          cyc = 0;
   int          last_xfer = -1;
   bit          gap_en = 0;

   uart_tx_scheduler dut (
      .clock           (clock),
      .reset           (reset),
      .i_req_valid     (i_req_valid),
      .i_req_data      (i_req_data),
      .o_req_ready     (o_req_ready),
      .o_user_tx_data  (o_user_tx_data),
      .o_user_tx_valid (o_user_tx_valid),
      .i_user_tx_ready (i_user_tx_ready),
      .o_grant_id      (o_grant_id),
      .o_busy          (o_busy)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic updateInputs();
      for (int k = 0; k < 4; k++) begin
         i_req_valid[k]      = (src_q[k].size() > 0);
         i_req_data[k*8 +: 8] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
      end
   endtask

   // Queue a byte at requester k, just after an edge so the next accept sees it.
   task automatic applyStimulus(input int k, input logic [7:0] b);
      src_q[k].push_back(b);
      updateInputs();
   endtask

   task automatic pushExpect(input logic [1:0] id, input logic [7:0] b, input bit change);
`ifdef UART_TX_SCHED_GRANT_ID_EN
      if (change) exp_q.push_back({id, 8'hA0 | {6'd0, id}});
`endif
      exp_q.push_back({id, b});
   endtask

   task automatic doReset();
      @(posedge clock); #2;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
   endtask

   task automatic waitDrain();
      bit done;
      done = 0;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && !o_busy && i_req_valid == 4'h0) done = 1;
      end
      checkOutput("drain_done", 32'(done), 32'd1);
   endtask

   always @(posedge clock) cyc++;

   // Monitor: capture accept pulses and score every driver handshake.
   always @(negedge clock) begin
      exp_t e;
      ready_seen = o_req_ready;
      if (reset && o_req_ready != 4'h0)
         checkOutput("ready_onehot", 32'($onehot(o_req_ready)), 32'd1);
      if (reset && o_user_tx_valid && i_user_tx_ready) begin
         xfer_pending = 1;
         checkOutput("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("tx_data", 32'(o_user_tx_data), 32'(e.data));
            checkOutput("grant_id", 32'(o_grant_id), 32'(e.id));
         end
         if (gap_en && last_xfer >= 0)
            checkOutput("xfer_gap", 32'((cyc - last_xfer) <= FRAME_LEN + 4), 32'd1);
         last_xfer = cyc;
      end
   end

   // Producers retire a byte once its accept pulse has been clocked in.
   always @(posedge clock) begin
      #1;
      for (int k = 0; k < 4; k++)
         if (ready_seen[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      ready_seen = '0;
      updateInputs();
   end

   // Driver model: ready drops after each byte for FRAME_LEN cycles.
   always @(posedge clock) begin
      #1;
      if (!reset) begin
         i_user_tx_ready = 1'b1;
         busy_cnt        = 0;
         xfer_pending    = 0;
      end else if (drv_hold) begin
         i_user_tx_ready = 1'b0;
      end else if (xfer_pending) begin
         xfer_pending    = 0;
         i_user_tx_ready = 1'b0;
         busy_cnt        = FRAME_LEN;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) i_user_tx_ready = 1'b1;
      end else begin
         i_user_tx_ready = 1'b1;
      end
   end

   initial begin
      logic [7:0] first;
      bit seen;

      // Test 1: reset held with all requests valid.
      for (int k = 0; k < 4; k++) applyStimulus(k, 8'hC0 + 8'(k));
      for (int k = 0; k < 4; k++) pushExpect(2'(k), 8'hC0 + 8'(k), 1);
      repeat (2) begin
         @(negedge clock);
         checkOutput("rst_ready", 32'(o_req_ready), 32'd0);
         checkOutput("rst_valid", 32'(o_user_tx_valid), 32'd0);
         checkOutput("rst_busy", 32'(o_busy), 32'd0);
         checkOutput("rst_grant", 32'(o_grant_id), 32'd0);
         checkOutput("rst_data", 32'(o_user_tx_data), 32'd0);
      end
      @(posedge clock); #2 reset = 1'b1;
      @(negedge clock);
      checkOutput("first_grant", 32'(o_req_ready), 32'h1);
      waitDrain();

      // Test 2: two competing requesters, burst of 4 then rotate.
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, 8'h10 + 8'(i));
         applyStimulus(2, 8'h20 + 8'(i));
      end
      for (int i = 0; i < 4; i++) pushExpect(2'd1, 8'h10 + 8'(i), i == 0);
      for (int i = 0; i < 4; i++) pushExpect(2'd2, 8'h20 + 8'(i), i == 0);
      pushExpect(2'd1, 8'h14, 1);
      pushExpect(2'd1, 8'h15, 0);
      pushExpect(2'd2, 8'h24, 1);
      pushExpect(2'd2, 8'h25, 0);
      waitDrain();

      // Test 3: lone requester keeps the grant across the burst limit.
      doReset();
      gap_en    = 1;
      last_xfer = -1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(3, 8'h30 + 8'(i));
         pushExpect(2'd3, 8'h30 + 8'(i), i == 0);
      end
      waitDrain();
      gap_en = 0;

      // Test 4: driver stalls while the byte is offered.
      doReset();
      drv_hold = 1;
      applyStimulus(0, 8'h40);
      applyStimulus(0, 8'h41);
      pushExpect(2'd0, 8'h40, 1);
      pushExpect(2'd0, 8'h41, 0);
`ifdef UART_TX_SCHED_GRANT_ID_EN
      first = 8'hA0;
`else
      first = 8'h40;
`endif
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         seen = o_user_tx_valid;
      end
      checkOutput("stall_valid_seen", 32'(seen), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checkOutput("stall_valid", 32'(o_user_tx_valid), 32'd1);
         checkOutput("stall_data", 32'(o_user_tx_data), 32'(first));
         checkOutput("stall_no_ready", 32'(o_req_ready[0]), 32'd0);
      end
      drv_hold = 0;
      waitDrain();

      // Test 5: reset while waiting for the driver to go busy.
      doReset();
      applyStimulus(1, 8'h50);
      pushExpect(2'd1, 8'h50, 1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clock);
         seen = o_user_tx_valid && i_user_tx_ready;
      end
      checkOutput("wlo_xfer_seen", 32'(seen), 32'd1);
      @(posedge clock); #2;
      checkOutput("wlo_busy", 32'(o_busy), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("wlo_rst_valid", 32'(o_user_tx_valid), 32'd0);
      checkOutput("wlo_rst_busy", 32'(o_busy), 32'd0);
      exp_q.delete();
      applyStimulus(2, 8'h52);
      applyStimulus(0, 8'h51);
      pushExpect(2'd0, 8'h51, 1);
      pushExpect(2'd2, 8'h52, 1);
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
      waitDrain();

      // Test 6: two single-byte grants in sequence.
      doReset();
      applyStimulus(2, 8'h55);
      pushExpect(2'd2, 8'h55, 1);
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clock); #2;
         seen = (src_q[2].size() == 0);
      end
      checkOutput("req2_accepted", 32'(seen), 32'd1);
      applyStimulus(0, 8'h66);
      pushExpect(2'd0, 8'h66, 1);
      waitDrain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
